// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage. Holds one instruction, waits for the
//               data-bus response of a load/store issued in EX, aligns and
//               extends load data, and hands the result to WB over the
//               valid/allow_in handshake. Exports a forwarding/stall bus to ID.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        es_to_ms_valid,
  input  logic [74:0] es_to_ms_bus,
  output logic        ms_allow_in,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allow_in,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic [38:0] ms_to_ds_bus
);

  localparam int ES_TO_MS_WD = 75;

  logic                   ms_valid;
  logic [ES_TO_MS_WD-1:0] bus_r;
  logic                   data_buf_valid;
  logic [31:0]            data_buf;

  logic        mem_req;
  logic        load_op;
  logic [1:0]  mem_size;
  logic        load_uns;
  logic        rf_we;
  logic [4:0]  dest;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic [1:0]  addr;

  logic        ready_go;
  logic        ms_leave;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] final_result;
  logic        fwd_valid;
  logic        fwd_block;

  assign {mem_req, load_op, mem_size, load_uns, rf_we, dest, pc, alu_result} = bus_r;
  assign addr = alu_result[1:0];

  // A memory op may leave once its response is seen now or was buffered earlier.
  assign ready_go       = !mem_req | data_sram_data_ok | data_buf_valid;
  assign ms_allow_in    = !ms_valid | (ready_go & ws_allow_in);
  assign ms_to_ws_valid = ms_valid & ready_go;
  assign ms_leave       = ms_to_ws_valid & ws_allow_in;

  // The bus only presents rdata for one cycle, so a stalled response is replayed from the buffer.
  assign load_data = data_buf_valid ? data_buf : data_sram_rdata;
  assign load_half = addr[1] ? load_data[31:16] : load_data[15:0];

  // Pick the addressed byte lane of the load word.
  always_comb begin
    load_byte = load_data[7:0];
    case (addr)
      2'd0: load_byte = load_data[7:0];
      2'd1: load_byte = load_data[15:8];
      2'd2: load_byte = load_data[23:16];
      2'd3: load_byte = load_data[31:24];
      default: load_byte = load_data[7:0];
    endcase
  end

  // Sign- or zero-extend according to access size; size 3 behaves as a word.
  always_comb begin
    load_ext = load_data;
    case (mem_size)
      2'd0: load_ext = {{24{~load_uns & load_byte[7]}}, load_byte};
      2'd1: load_ext = {{16{~load_uns & load_half[15]}}, load_half};
      default: load_ext = load_data;
    endcase
  end

  assign final_result = load_op ? load_ext : alu_result;

  // ID must stall on a match against a load whose data has not yet arrived.
  assign fwd_valid = ms_valid & rf_we & (dest != 5'd0);
  assign fwd_block = ms_valid & load_op & !ready_go;

  assign ms_to_ws_bus = {rf_we, dest, pc, final_result};
  assign ms_to_ds_bus = {fwd_valid, fwd_block, dest, final_result};

  // Stage occupancy advances whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ms_valid <= 1'b0;
    end else if (ms_allow_in) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // The held instruction changes only on an actual transfer from EX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_r <= '0;
    end else if (es_to_ms_valid && ms_allow_in) begin
      bus_r <= es_to_ms_bus;
    end
  end

  // Keep a response that arrives while WB stalls; drop it when the instruction leaves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_buf_valid <= 1'b0;
      data_buf       <= 32'd0;
    end else if (ms_leave) begin
      data_buf_valid <= 1'b0;
    end else if (ms_valid && mem_req && data_sram_data_ok && !ws_allow_in && !data_buf_valid) begin
      data_buf_valid <= 1'b1;
      data_buf       <= data_sram_rdata;
    end
  end

endmodule
`default_nettype wire
